// File: rtl/calendar_pkg.sv
// Shared calendar constants and helpers for the date counter and its leap-year unit.
package calendar_pkg;

   localparam logic [3:0] JAN = 4'd1;
   localparam logic [3:0] FEB = 4'd2;
   localparam logic [3:0] MAR = 4'd3;
   localparam logic [3:0] APR = 4'd4;
   localparam logic [3:0] MAY = 4'd5;
   localparam logic [3:0] JUN = 4'd6;
   localparam logic [3:0] JUL = 4'd7;
   localparam logic [3:0] AUG = 4'd8;
   localparam logic [3:0] SEP = 4'd9;
   localparam logic [3:0] OCT = 4'd10;
   localparam logic [3:0] NOV = 4'd11;
   localparam logic [3:0] DEC = 4'd12;

   localparam logic [2:0] MON = 3'd0;
   localparam logic [2:0] TUE = 3'd1;
   localparam logic [2:0] WED = 3'd2;
   localparam logic [2:0] THU = 3'd3;
   localparam logic [2:0] FRI = 3'd4;
   localparam logic [2:0] SAT = 3'd5;
   localparam logic [2:0] SUN = 3'd6;
   localparam logic [2:0] WDAY_RST = SAT;

   function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap);
      logic [4:0] len;
      case (month)
         FEB:                len = leap ? 5'd29 : 5'd28;
         APR, JUN, SEP, NOV: len = 5'd30;
         default:            len = 5'd31;
      endcase
      return len;
   endfunction

   // Elaboration-time twin of leap_year_calc, used only for reset constants.
   function automatic logic leap_of(input int year);
      return ((year % 4 == 0) && (year % 100 != 0)) || (year % 400 == 0);
   endfunction

endpackage

// File: rtl/leap_year_calc.sv
// Combinational Gregorian leap-year test for an arbitrary-width year.
module leap_year_calc #(
   parameter int YEAR_W = 12
) (
   input  logic [YEAR_W-1:0] year,
   output logic              leap
);

   // Widened so the divisors 100 and 400 fit even for very narrow years.
   localparam int EW = YEAR_W + 10;

   logic [EW-1:0] year_ext;
   logic          div4;
   logic          div100;
   logic          div400;

   assign year_ext = EW'(year);
   assign div4     = (year_ext[1:0] == 2'b00);
   assign div100   = ((year_ext % EW'(100)) == '0);
   assign div400   = ((year_ext % EW'(400)) == '0);
   assign leap     = (div4 && !div100) || div400;

endmodule

// File: rtl/calendar_date_counter.sv
// Day/month/year counter with forward/backward day steps and a validated load.
// Optional weekday tracking is enabled by defining CAL_WEEKDAY_EN.
module calendar_date_counter
   import calendar_pkg::*;
#(
   parameter int YEAR_W    = 12,
   parameter int YEAR_MIN  = 2000,
   parameter int YEAR_MAX  = 3000,
   parameter int RST_YEAR  = 2000,
   parameter int RST_MONTH = 1,
   parameter int RST_DAY   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              day_tick,
   input  logic              day_tick_dn,
   input  logic              load,
   input  logic [YEAR_W-1:0] load_year,
   input  logic [3:0]        load_month,
   input  logic [4:0]        load_day,
`ifdef CAL_WEEKDAY_EN
   input  logic [2:0]        load_wday,
   output logic [2:0]        wday,
`endif
   output logic [YEAR_W-1:0] year,
   output logic [3:0]        month,
   output logic [4:0]        day,
   output logic              is_leap,
   output logic [4:0]        days_in_month,
   output logic              month_carry,
   output logic              year_carry,
   output logic              range_wrap,
   output logic              load_err
);

   localparam logic [YEAR_W-1:0] Y_MIN   = YEAR_W'(YEAR_MIN);
   localparam logic [YEAR_W-1:0] Y_MAX   = YEAR_W'(YEAR_MAX);
   localparam logic [YEAR_W-1:0] R_YEAR  = YEAR_W'(RST_YEAR);
   localparam logic [3:0]        R_MONTH = 4'(RST_MONTH);
   localparam logic [4:0]        R_DAY   = 5'(RST_DAY);
   localparam logic              R_LEAP  = leap_of(RST_YEAR);
   localparam logic [4:0]        R_DIM   = month_len(R_MONTH, R_LEAP);

   logic [YEAR_W-1:0] year_q, year_d;
   logic [3:0]        month_q, month_d;
   logic [4:0]        day_q, day_d;
   logic              leap_q, leap_d;
   logic [4:0]        dim_q, dim_d;
   logic              month_carry_q, month_carry_d;
   logic              year_carry_q, year_carry_d;
   logic              range_wrap_q, range_wrap_d;
   logic              load_err_q, load_err_d;

   logic              ld_leap;
   logic [4:0]        ld_len;
   logic              ld_ok;

   leap_year_calc #(.YEAR_W(YEAR_W)) u_leap_next (
      .year (year_d),
      .leap (leap_d)
   );

   leap_year_calc #(.YEAR_W(YEAR_W)) u_leap_load (
      .year (load_year),
      .leap (ld_leap)
   );

   assign ld_len = month_len(load_month, ld_leap);

`ifdef CAL_WEEKDAY_EN
   logic [2:0] wday_q, wday_d;
   logic       ld_wday_ok;

   assign ld_wday_ok = (load_wday <= SUN);
`else
   logic       ld_wday_ok;

   assign ld_wday_ok = 1'b1;
`endif

   assign ld_ok = (load_year >= Y_MIN) && (load_year <= Y_MAX)
               && (load_month >= JAN) && (load_month <= DEC)
               && (load_day != 5'd0) && (load_day <= ld_len)
               && ld_wday_ok;

   // NOTE: every signal gets a default at the top so no path infers a latch.
   always_comb begin
      year_d        = year_q;
      month_d       = month_q;
      day_d         = day_q;
      month_carry_d = 1'b0;
      year_carry_d  = 1'b0;
      range_wrap_d  = 1'b0;
      load_err_d    = 1'b0;

      if (load) begin
         if (ld_ok) begin
            year_d  = load_year;
            month_d = load_month;
            day_d   = load_day;
         end else begin
            load_err_d = 1'b1;
         end
      end else if (day_tick) begin
         if (day_q < dim_q) begin
            day_d = day_q + 5'd1;
         end else begin
            day_d         = 5'd1;
            month_carry_d = 1'b1;
            if (month_q == DEC) begin
               month_d      = JAN;
               year_carry_d = 1'b1;
               if (year_q == Y_MAX) begin
                  year_d       = Y_MIN;
                  range_wrap_d = 1'b1;
               end else begin
                  year_d = year_q + YEAR_W'(1);
               end
            end else begin
               month_d = month_q + 4'd1;
            end
         end
      end else if (day_tick_dn) begin
         if (day_q > 5'd1) begin
            day_d = day_q - 5'd1;
         end else begin
            month_carry_d = 1'b1;
            if (month_q == JAN) begin
               month_d      = DEC;
               day_d        = 5'd31;
               year_carry_d = 1'b1;
               if (year_q == Y_MIN) begin
                  year_d       = Y_MAX;
                  range_wrap_d = 1'b1;
               end else begin
                  year_d = year_q - YEAR_W'(1);
               end
            end else begin
               // Same year, so the current leap flag sizes the previous month.
               month_d = month_q - 4'd1;
               day_d   = month_len(month_q - 4'd1, leap_q);
            end
         end
      end
   end

   assign dim_d = month_len(month_d, leap_d);

`ifdef CAL_WEEKDAY_EN
   always_comb begin
      wday_d = wday_q;
      if (load) begin
         if (ld_ok) begin
            wday_d = load_wday;
         end
      end else if (day_tick) begin
         wday_d = (wday_q == SUN) ? MON : wday_q + 3'd1;
      end else if (day_tick_dn) begin
         wday_d = (wday_q == MON) ? SUN : wday_q - 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wday_q <= WDAY_RST;
      end else begin
         wday_q <= wday_d;
      end
   end

   assign wday = wday_q;
`endif

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         year_q        <= R_YEAR;
         month_q       <= R_MONTH;
         day_q         <= R_DAY;
         leap_q        <= R_LEAP;
         dim_q         <= R_DIM;
         month_carry_q <= 1'b0;
         year_carry_q  <= 1'b0;
         range_wrap_q  <= 1'b0;
         load_err_q    <= 1'b0;
      end else begin
         year_q        <= year_d;
         month_q       <= month_d;
         day_q         <= day_d;
         leap_q        <= leap_d;
         dim_q         <= dim_d;
         month_carry_q <= month_carry_d;
         year_carry_q  <= year_carry_d;
         range_wrap_q  <= range_wrap_d;
         load_err_q    <= load_err_d;
      end
   end

   assign year          = year_q;
   assign month         = month_q;
   assign day           = day_q;
   assign is_leap       = leap_q;
   assign days_in_month = dim_q;
   assign month_carry   = month_carry_q;
   assign year_carry    = year_carry_q;
   assign range_wrap    = range_wrap_q;
   assign load_err      = load_err_q;

endmodule

// File: tb/tb_calendar_date_counter.sv
// Scoreboard bench for calendar_date_counter against an independent date model.
module tb_calendar_date_counter;

   localparam int YMIN = 2000;
   localparam int YMAX = 3000;

   logic        clk = 1'b0;
   logic        rst;
   logic        day_tick, day_tick_dn, load;
   logic [11:0] load_year;
   logic [3:0]  load_month;
   logic [4:0]  load_day;
   logic [11:0] year;
   logic [3:0]  month;
   logic [4:0]  day;
   logic        is_leap;
   logic [4:0]  days_in_month;
   logic        month_carry, year_carry, range_wrap, load_err;
`ifdef CAL_WEEKDAY_EN
   logic [2:0]  load_wday;
   logic [2:0]  wday;
`endif

   calendar_date_counter dut (
      .clk           (clk),
      .rst           (rst),
      .day_tick      (day_tick),
      .day_tick_dn   (day_tick_dn),
      .load          (load),
      .load_year     (load_year),
      .load_month    (load_month),
      .load_day      (load_day),
`ifdef CAL_WEEKDAY_EN
      .load_wday     (load_wday),
      .wday          (wday),
`endif
      .year          (year),
      .month         (month),
      .day           (day),
      .is_leap       (is_leap),
      .days_in_month (days_in_month),
      .month_carry   (month_carry),
      .year_carry    (year_carry),
      .range_wrap    (range_wrap),
      .load_err      (load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int year, month, day, leap, dim, mc, yc, rw, le, wday;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   m_year, m_month, m_day, m_wday;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int leap_y(input int y);
      if (y % 400 == 0) return 1;
      if (y % 100 == 0) return 0;
      return (y % 4 == 0) ? 1 : 0;
   endfunction

   function automatic int mlen(input int m, input int y);
      case (m)
         2:            return leap_y(y) ? 29 : 28;
         4, 6, 9, 11:  return 30;
         default:      return 31;
      endcase
   endfunction

   task automatic model_reset();
      m_year = 2000; m_month = 1; m_day = 1; m_wday = 5;
   endtask

   task automatic model(input bit t, input bit dn, input bit ld, input int ly, input int lm,
                        input int ldd, input int lw, output exp_t e);
      bit ok;
      e = '{default: 0};
      if (ld) begin
         ok = (ly >= YMIN) && (ly <= YMAX) && (lm >= 1) && (lm <= 12);
         if (ok) ok = (ldd >= 1) && (ldd <= mlen(lm, ly));
`ifdef CAL_WEEKDAY_EN
         if (lw > 6) ok = 0;
`endif
         if (ok) begin
            m_year = ly; m_month = lm; m_day = ldd; m_wday = lw;
         end else begin
            e.le = 1;
         end
      end else if (t) begin
         m_wday = (m_wday + 1) % 7;
         if (m_day < mlen(m_month, m_year)) m_day++;
         else begin
            m_day = 1; e.mc = 1;
            if (m_month == 12) begin
               m_month = 1; e.yc = 1;
               if (m_year == YMAX) begin m_year = YMIN; e.rw = 1; end
               else m_year++;
            end else m_month++;
         end
      end else if (dn) begin
         m_wday = (m_wday + 6) % 7;
         if (m_day > 1) m_day--;
         else begin
            e.mc = 1;
            if (m_month == 1) begin
               m_month = 12; m_day = 31; e.yc = 1;
               if (m_year == YMIN) begin m_year = YMAX; e.rw = 1; end
               else m_year--;
            end else begin
               m_month--;
               m_day = mlen(m_month, m_year);
            end
         end
      end
      e.year = m_year; e.month = m_month; e.day = m_day; e.wday = m_wday;
      e.leap = leap_y(m_year); e.dim = mlen(m_month, m_year);
   endtask

   task automatic compare(input exp_t e);
      check("year", 32'(year), e.year);
      check("month", 32'(month), e.month);
      check("day", 32'(day), e.day);
      check("is_leap", 32'(is_leap), e.leap);
      check("days_in_month", 32'(days_in_month), e.dim);
      check("month_carry", 32'(month_carry), e.mc);
      check("year_carry", 32'(year_carry), e.yc);
      check("range_wrap", 32'(range_wrap), e.rw);
      check("load_err", 32'(load_err), e.le);
`ifdef CAL_WEEKDAY_EN
      check("wday", 32'(wday), e.wday);
`endif
   endtask

   task automatic step(input bit t, input bit dn, input bit ld, input int ly = 0,
                       input int lm = 0, input int ldd = 0, input int lw = 0);
      exp_t e;
      @(negedge clk);
      day_tick = t; day_tick_dn = dn; load = ld;
      load_year = ly[11:0]; load_month = lm[3:0]; load_day = ldd[4:0];
`ifdef CAL_WEEKDAY_EN
      load_wday = lw[2:0];
`endif
      model(t, dn, ld, ly, lm, ldd, lw, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) check("sb_empty", 1, 0);
      else compare(sb.pop_front());
      day_tick = 0; day_tick_dn = 0; load = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_year"}, 32'(year), 2000);
      check({tag, "_month"}, 32'(month), 1);
      check({tag, "_day"}, 32'(day), 1);
      check({tag, "_leap"}, 32'(is_leap), 1);
      check({tag, "_dim"}, 32'(days_in_month), 31);
      check({tag, "_pulses"}, 32'({month_carry, year_carry, range_wrap, load_err}), 0);
`ifdef CAL_WEEKDAY_EN
      check({tag, "_wday"}, 32'(wday), 5);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int r, ly, lm, ldd, lw;
      rst = 1; day_tick = 0; day_tick_dn = 0; load = 0;
      load_year = '0; load_month = '0; load_day = '0;
`ifdef CAL_WEEKDAY_EN
      load_wday = '0;
`endif
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("rst");
      @(negedge clk);
      rst = 0;

      // Leap February in 2000.
      repeat (59) step(1, 0, 0);
      check("feb29_day", 32'(day), 29);
      check("feb29_month", 32'(month), 2);
      step(1, 0, 0);
      check("mar01_mc", 32'(month_carry), 1);
      check("mar01_month", 32'(month), 3);

      // Century rules.
      step(0, 0, 1, 2100, 2, 28);
      check("y2100_leap", 32'(is_leap), 0);
      step(1, 0, 0);
      check("y2100_mar01", 32'({month, day}), {4'd3, 5'd1});
      step(0, 0, 1, 2400, 2, 28);
      step(1, 0, 0);
      check("y2400_feb29", 32'({month, day}), {4'd2, 5'd29});
      check("y2400_leap", 32'(is_leap), 1);

      // Range wrap in both directions.
      step(0, 0, 1, 3000, 12, 31);
      step(1, 0, 0);
      check("wrap_fwd", 32'({range_wrap, year_carry, month_carry}), 3'b111);
      check("wrap_fwd_year", 32'(year), 2000);
      step(0, 1, 0);
      check("wrap_bwd_year", 32'(year), 3000);
      check("wrap_bwd_rw", 32'(range_wrap), 1);

      // Rejected loads leave the date alone.
      step(0, 0, 1, 2023, 2, 29);
      check("rej_feb29_err", 32'(load_err), 1);
      check("rej_feb29_year", 32'(year), 3000);
      step(0, 0, 1, 2023, 13, 1);
      step(0, 0, 1, 1999, 6, 1);
      step(0, 0, 1, 3001, 6, 1);
      step(0, 0, 1, 2024, 6, 0);
      step(0, 0, 1, 2024, 0, 5);
      step(0, 0, 1, 2024, 4, 31);
`ifdef CAL_WEEKDAY_EN
      step(0, 0, 1, 2024, 4, 3, 7);
      check("rej_wday_err", 32'(load_err), 1);
`endif

      // Backward across March 1st.
      step(0, 0, 1, 2024, 3, 1, 4);
      step(0, 1, 0);
      check("bwd_leap_feb", 32'(day), 29);
      step(0, 0, 1, 2023, 3, 1, 2);
      step(0, 1, 0);
      check("bwd_plain_feb", 32'(day), 28);
      step(0, 0, 1, 2001, 1, 1, 0);
      step(0, 1, 0);
      check("bwd_year", 32'({month, day}), {4'd12, 5'd31});

      // Priority.
      step(1, 1, 1, 2024, 5, 10, 4);
      check("ld_prio_day", 32'(day), 10);
      check("ld_prio_mc", 32'(month_carry), 0);
      step(1, 1, 0);
      check("both_fwd", 32'(day), 11);
      step(0, 0, 0);

      // Mixed random traffic.
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 19);
         if (r < 10) step(1, 0, 0);
         else if (r < 16) step(0, 1, 0);
         else if (r < 17) step(1, 1, 0);
         else if (r < 18) step(0, 0, 0);
         else begin
            ly  = (r == 18) ? $urandom_range(1995, 3005) : (($urandom_range(0, 1) == 1) ? 3000 : 2000);
            lm  = $urandom_range(0, 14);
            ldd = $urandom_range(0, 31);
            lw  = $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 0) begin
               lm  = (ly == 3000) ? 12 : 1;
               ldd = (ly == 3000) ? 31 : 1;
               lw  = $urandom_range(0, 6);
            end
            step($urandom_range(0, 1), $urandom_range(0, 1), 1, ly, lm, ldd, lw);
         end
      end

      // Asynchronous reset with a pending tick.
      step(0, 0, 1, 2024, 7, 15, 1);
      @(negedge clk);
      day_tick = 1;
      #2;
      rst = 1;
      #1;
      check_reset_state("async_rst");
      @(posedge clk);
      #1;
      check_reset_state("held_rst");
      day_tick = 0;
      @(negedge clk);
      rst = 0;
      model_reset();
      repeat (7) step(1, 0, 0);
      check("week_day", 32'(day), 8);
`ifdef CAL_WEEKDAY_EN
      check("week_wday", 32'(wday), 5);
`endif

      if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/calendar_date_counter.md
Name: calendar_date_counter

Overview:
- Parametrised day/month/year calendar counter with full Gregorian leap-year rule for any year width and range.
- Driven by a one-cycle day tick from the time-of-day chain; supports forward and backward stepping and a validated date load.
- Sits between the hours counter and the display/alarm logic. Supplies is_leap and days_in_month to downstream blocks.

Parameters:
- YEAR_W, 12, width of the year field.
- YEAR_MIN, 2000, lowest representable year; wrap target on forward overflow.
- YEAR_MAX, 3000, highest representable year; wrap target on backward underflow. Requires YEAR_MIN < YEAR_MAX < 2**YEAR_W.
- RST_YEAR, 2000, year after reset.
- RST_MONTH, 1, month after reset (1..12).
- RST_DAY, 1, day after reset (must be valid for RST_MONTH/RST_YEAR).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- day_tick  in  1  single-cycle pulse: advance one day
- day_tick_dn  in  1  single-cycle pulse: step back one day
- load  in  1  single-cycle pulse: load date from load_* inputs
- load_year  in  YEAR_W  year to load
- load_month  in  4  month to load (1..12)
- load_day  in  5  day to load (1..31)
- year  out  YEAR_W  current year
- month  out  4  current month (1..12)
- day  out  5  current day (1..31)
- is_leap  out  1  current year is a leap year
- days_in_month  out  5  length of current month (28..31)
- month_carry  out  1  one-cycle pulse: month changed due to tick
- year_carry  out  1  one-cycle pulse: year changed due to tick
- range_wrap  out  1  one-cycle pulse: year wrapped YEAR_MAX<->YEAR_MIN
- load_err  out  1  one-cycle pulse: load rejected

Behaviour:
- Reset (async assert, state held while rst=1):
  - year/month/day = RST_*.
  - is_leap and days_in_month match the reset date.
  - All pulses = 0.
- Leap rule: leap iff (Y%4==0 && Y%100!=0) || Y%400==0. No year is hard-coded.
- Register update timing:
  - is_leap and days_in_month are registered.
  - Both are computed from the next-state year/month, so they update in the same cycle as year/month.
  - They are never stale by even one cycle.
- Priority per cycle: load > day_tick > day_tick_dn.
  - day_tick and day_tick_dn together: forward step only.
  - Ignored inputs leave no side effect.
- Forward tick:
  - day<days_in_month: day+1.
  - Otherwise: day=1 and month_carry=1.
  - If month was 12: month=1, year_carry=1, and year+1. If year was YEAR_MAX, year=YEAR_MIN and range_wrap=1.
- Backward tick:
  - day>1: day-1.
  - Otherwise: month-1, day = length of the new month, month_carry=1.
  - If month was 1: month=12, day=31, year-1, year_carry=1. If year was YEAR_MIN, year=YEAR_MAX and range_wrap=1.
  - Day 1 Mar steps back to 29 Feb in a leap year, else 28 Feb.
- Load validation: accepted iff all of:
  - YEAR_MIN<=load_year<=YEAR_MAX
  - 1<=load_month<=12
  - 1<=load_day<=length(load_month, load_year)
- Load result:
  - Accepted: registers update next edge; no carry pulses.
  - Rejected: state unchanged; load_err=1 for one cycle.
- Latency: all outputs change on the edge following the sampling input. Pulses are registered, one cycle wide, and aligned with the state change.
- Reset mid-operation: any pending tick/load is discarded.

Optional Feature:
- Macro: CAL_WEEKDAY_EN
- Defined:
  - Adds input load_wday[2:0] (0=Mon..6=Sun) and output wday[2:0].
  - Reset value 5 (RST date 2000-01-01 is Saturday).
  - Forward tick: 6 wraps to 0. Backward tick: 0 wraps to 6.
  - Accepted load sets wday=load_wday. load_wday>6 rejects the whole load (load_err).
- Undefined: ports absent; no weekday logic.

Decomposition:
- Package calendar_pkg:
  - month constants JAN..DEC.
  - function month_len(month, leap) returning 28..31.
  - weekday constants and WDAY_RST.
- Sub-module leap_year_calc: parametrised by YEAR_W, purely combinational (year -> leap).
  - Two instances: one for the next-state year, one for load validation.

Test Plan:
- Reset, then 59 forward ticks -> 2000-02-29 (leap); 1 more tick -> 2000-03-01, month_carry=1.
- Load 2100-02-28, tick -> 2100-03-01, is_leap=0 throughout (century non-leap); load 2400-02-28, tick -> 2400-02-29, is_leap=1.
- Load 3000-12-31, tick -> 2000-01-01 with month_carry=year_carry=range_wrap=1 in the same cycle; backward tick -> 3000-12-31, range_wrap=1.
- Load 2023-02-29 -> load_err=1, date unchanged. Load month 13 or year 1999 -> load_err=1.
- Load and day_tick in the same cycle with load 2024-05-10 -> 2024-05-10, no carries. day_tick+day_tick_dn together -> +1 day.
- Assert rst while a tick is pending -> outputs immediately return to 2000-01-01. With CAL_WEEKDAY_EN, wday=5, and after 7 ticks wday=5.
